// File: rtl/addsub_pkg.sv
// Shared widths, opcode encodings and FSM state type for the add/subtract arbiter.
package addsub_pkg;
  localparam int OPND_W = 4;
  localparam int RES_W  = 8;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;
endpackage

// File: rtl/add_subtract.sv
// Combinational add/subtract datapath: unsigned operands are zero-extended to
// RES_W; a subtraction that goes below zero wraps modulo 2^RES_W.
module add_subtract
  import addsub_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  input  logic              op,
  output logic [RES_W-1:0]  result
);

  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;

  assign a_ext = {{(RES_W-OPND_W){1'b0}}, a};
  assign b_ext = {{(RES_W-OPND_W){1'b0}}, b};

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a_ext + b_ext;
      OP_SUB:  result = a_ext - b_ext;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester arbiter in front of a single add_subtract datapath (IDLE/EXEC/RESP).
// Define ADDSUB_RR_EN for round-robin arbitration; default is fixed priority to req0.
module addsub_arbiter
  import addsub_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OPND_W-1:0] req0_a,
  input  logic [OPND_W-1:0] req0_b,
  input  logic              req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OPND_W-1:0] req1_a,
  input  logic [OPND_W-1:0] req1_b,
  input  logic              req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_data,
  output logic              rsp_id
);

  state_t            state;
  state_t            state_nxt;
  logic              grant;
  logic              accept;
  logic [OPND_W-1:0] a_q;
  logic [OPND_W-1:0] b_q;
  logic              op_q;
  logic              id_q;
  logic [RES_W-1:0]  result;

  assign accept = (state == ST_IDLE) && (req0_valid || req1_valid);

`ifdef ADDSUB_RR_EN
  logic last_grant;

  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = req1_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (accept) last_grant <= grant;
  end
`else
  always_comb grant = ~req0_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Ready is masked by rst_n so that both readies read 0 while reset is held.
  always_comb begin
    req0_ready = rst_n && accept && !grant;
    req1_ready = rst_n && accept &&  grant;
    rsp_valid  = (state == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      id_q     <= 1'b0;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
    end else begin
      if (accept) begin
        a_q  <= grant ? req1_a  : req0_a;
        b_q  <= grant ? req1_b  : req0_b;
        op_q <= grant ? req1_op : req0_op;
        id_q <= grant;
      end
      if (state == ST_EXEC) begin
        rsp_data <= result;
        rsp_id   <= id_q;
      end
    end
  end

  add_subtract u_add_subtract (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (result)
  );

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: per-cycle transaction model plus directed vectors.
module tb_addsub_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       req0_op = 1'b0, req1_op = 1'b0;
  logic       rsp_ready = 1'b0;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [7:0] rsp_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addsub_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_age = -1 nothing in flight, 0 operation accepted on the last edge,
  // >=1 result is on offer to the consumer.
  int m_age  = -1;
  int m_res  = 0;
  int m_id   = 0;
  int m_last = 1;

  function automatic int pick();
    if (req0_valid && req1_valid) begin
`ifdef ADDSUB_RR_EN
      return 1 - m_last;
`else
      return 0;
`endif
    end
    return req1_valid ? 1 : 0;
  endfunction

  function automatic int arith(input int a, input int b, input int op);
    if (op != 0) return a + b;
    return (a - b + 256) % 256;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age  <= -1;
      m_last <= 1;
    end else if (m_age < 0) begin
      if (req0_valid || req1_valid) begin
        automatic int g = pick();
        m_age  <= 0;
        m_last <= g;
        m_id   <= g;
        m_res  <= (g == 0) ? arith(req0_a, req0_b, req0_op) : arith(req1_a, req1_b, req1_op);
      end
    end else if (m_age == 0) begin
      m_age <= 1;
    end else if (rsp_ready) begin
      m_age <= -1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
    end else begin
      automatic int e0 = 0;
      automatic int e1 = 0;
      if (m_age < 0 && (req0_valid || req1_valid)) begin
        if (pick() == 0) e0 = 1;
        else             e1 = 1;
      end
      check("model_rsp_valid", rsp_valid, (m_age >= 1) ? 1 : 0);
      check("model_req0_ready", req0_ready, e0);
      check("model_req1_ready", req1_ready, e1);
      if (m_age >= 1) begin
        check("model_rsp_data", rsp_data, m_res);
        check("model_rsp_id", rsp_id, m_id);
      end
    end
  end

  task automatic issue(input int r, input logic [3:0] a, input logic [3:0] b, input logic op);
    int n;
    @(posedge clk); #1;
    if (r == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if ((r == 0) ? req0_ready : req1_ready) break;
    end
    if (n == 20) check("issue_timeout", 0, 1);
    @(posedge clk); #1;
    if (r == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    int ids[$];
`ifdef ADDSUB_RR_EN
    int exp_ids[4] = '{0, 1, 0, 1};
`else
    int exp_ids[4] = '{0, 0, 0, 0};
`endif

    #1 rst_n = 1'b0;
    req0_valid = 1'b1;
    #2;
    check("reset_req0_ready", req0_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    repeat (2) @(posedge clk);
    #1 req0_valid = 1'b0;
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // Single add
    issue(0, 4'd9, 4'd6, 1'b1);
    wait_rsp(n);
    check("add_latency", n, 2);
    check("add_data", rsp_data, 15);
    check("add_id", rsp_id, 0);

    // Subtract wraps modulo 256
    issue(1, 4'd3, 4'd5, 1'b0);
    wait_rsp(n);
    check("sub_latency", n, 2);
    check("sub_data", rsp_data, 8'hFE);
    check("sub_id", rsp_id, 1);

    // Backpressure for five cycles, maximum sum
    @(posedge clk); #1 rsp_ready = 1'b0;
    issue(0, 4'd15, 4'd15, 1'b1);
    wait_rsp(n);
    check("bp_latency", n, 2);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 30);
      check("bp_id", rsp_id, 0);
      check("bp_ready0", req0_ready, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_last_valid", rsp_valid, 1);
    @(negedge clk);
    check("bp_done", rsp_valid, 0);

    // req1 pulsed for one cycle while a response is stalled
    @(posedge clk); #1 rsp_ready = 1'b0;
    issue(0, 4'd2, 4'd3, 1'b1);
    wait_rsp(n);
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1; req1_op = 1'b1;
    @(negedge clk);
    check("drop_ready1", req1_ready, 0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(negedge clk);
    check("drop_own_data", rsp_data, 5);
    check("drop_own_id", rsp_id, 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("drop_no_rsp", seen, 0);

    // Reset while in EXEC, then contention from both requesters
    issue(0, 4'd7, 4'd2, 1'b1);
    #1 rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd4; req0_b = 4'd1; req0_op = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2; req1_op = 1'b1;
    #1;
    check("midrst_valid", rsp_valid, 0);
    check("midrst_data", rsp_data, 0);
    check("midrst_id", rsp_id, 0);
    check("midrst_ready0", req0_ready, 0);
    check("midrst_ready1", req1_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 60 && ids.size() < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ids.push_back(int'(rsp_id));
        check("cont_data", rsp_data, rsp_id ? 4 : 3);
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("cont_count", ids.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ids.size()) check("cont_grant", ids[i], exp_ids[i]);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
